t05_spi_xfer_scheduler: RTL and testbench

T05_SPI_XFER_SCHEDULER -- requirements
Module: t05_spi_xfer_scheduler

---
 rtl/t05_spi_pkg.sv | 18 +
 rtl/t05_spi_tick_gen.sv | 29 ++
 rtl/t05_spi_xfer_scheduler.sv | 151 +++++++++++++++
 tb/tb_t05_spi_xfer_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/t05_spi_pkg.sv
// Shared types and constants for the two-requester SPI transfer scheduler.
package t05_spi_pkg;

  localparam int unsigned DIV_HALF_DEFAULT = 512;
  localparam int unsigned TICK_W           = 10;
  localparam int unsigned BIT_W            = 4;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned REQ_N            = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/t05_spi_tick_gen.sv
// SCLK half-period tick generator: counts 0..DIV_HALF-1 while enabled, pulses tick on the last count.
module t05_spi_tick_gen
  import t05_spi_pkg::*;
#(
  parameter int unsigned DIV_HALF = DIV_HALF_DEFAULT
) (
  input  logic current_clock_signal,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  logic [TICK_W-1:0] count;

  assign tick = enable && (count == TICK_W'(DIV_HALF - 1));

  // Disabled states hold the count at zero so every active state starts a fresh half-period.
  always_ff @(posedge current_clock_signal or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/t05_spi_xfer_scheduler.sv
// Round-robin scheduler that runs one SPI mode-0 byte exchange at a time for two requesters.
module t05_spi_xfer_scheduler
  import t05_spi_pkg::*;
#(
  parameter int unsigned DIV_HALF = DIV_HALF_DEFAULT
) (
  input  logic              current_clock_signal,
  input  logic              reset,
  input  logic [REQ_N-1:0]  req,
  input  logic [BYTE_W-1:0] tx_byte_0,
  input  logic [BYTE_W-1:0] tx_byte_1,
  input  logic              miso,
  output logic [REQ_N-1:0]  grant,
  output logic              busy,
  output logic [REQ_N-1:0]  done,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              sclk,
  output logic              mosi,
  output logic [REQ_N-1:0]  cs_n
);

  state_e            state, state_next;
  logic              owner, owner_next;
  logic              ptr, ptr_next;
  logic [BYTE_W-1:0] tx_sh, tx_sh_next;
  logic [BYTE_W-1:0] rx_sh, rx_sh_next;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [REQ_N-1:0]  grant_next, done_next, cs_n_next;
  logic [BYTE_W-1:0] rx_byte_next;
  logic              busy_next, sclk_next, mosi_next;
  logic              win_c;
  logic [BYTE_W-1:0] sel_byte_c;
  logic              tick_en_c, tick_clr_c, tick;

  assign tick_en_c  = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign tick_clr_c = (state_next != state);

  t05_spi_tick_gen #(.DIV_HALF(DIV_HALF)) u_tick_gen (
    .current_clock_signal (current_clock_signal),
    .reset                (reset),
    .enable               (tick_en_c),
    .clear                (tick_clr_c),
    .tick                 (tick)
  );

  // Next-state and next-register values.
  always_comb begin
    state_next   = state;
    owner_next   = owner;
    ptr_next     = ptr;
    tx_sh_next   = tx_sh;
    rx_sh_next   = rx_sh;
    bit_cnt_next = bit_cnt;
    grant_next   = grant;
    busy_next    = busy;
    done_next    = '0;
    rx_byte_next = rx_byte;
    sclk_next    = sclk;
    mosi_next    = mosi;
    cs_n_next    = cs_n;
    win_c        = 1'b0;
    sel_byte_c   = tx_byte_0;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          // Contention goes to whoever was not served last.
          win_c        = (req == 2'b11) ? ~ptr : req[1];
          sel_byte_c   = win_c ? tx_byte_1 : tx_byte_0;
          state_next   = ST_SETUP;
          owner_next   = win_c;
          grant_next   = win_c ? 2'b10 : 2'b01;
          cs_n_next    = win_c ? 2'b01 : 2'b10;
          tx_sh_next   = sel_byte_c;
          mosi_next    = sel_byte_c[BYTE_W-1];
          busy_next    = 1'b1;
          bit_cnt_next = '0;
          sclk_next    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_next = ~sclk;
          if (!sclk) begin
            rx_sh_next = {rx_sh[BYTE_W-2:0], miso};
          end else if (bit_cnt != 4'd15) begin
            tx_sh_next = {tx_sh[BYTE_W-2:0], 1'b0};
            mosi_next  = tx_sh[BYTE_W-2];
          end
          if (bit_cnt == 4'd15) begin
            state_next   = ST_HOLD;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_next   = ST_DONE;
          done_next    = grant;
          grant_next   = '0;
          cs_n_next    = 2'b11;
          rx_byte_next = rx_sh;
          ptr_next     = owner;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge current_clock_signal or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b1;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= '0;
      rx_byte <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 2'b11;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      ptr     <= ptr_next;
      tx_sh   <= tx_sh_next;
      rx_sh   <= rx_sh_next;
      bit_cnt <= bit_cnt_next;
      grant   <= grant_next;
      busy    <= busy_next;
      done    <= done_next;
      rx_byte <= rx_byte_next;
      sclk    <= sclk_next;
      mosi    <= mosi_next;
      cs_n    <= cs_n_next;
    end
  end

endmodule

// File: tb/tb_t05_spi_xfer_scheduler.sv
// Self-checking bench for t05_spi_xfer_scheduler at DIV_HALF=4 against a transaction-level model.
module tb_t05_spi_xfer_scheduler;

  localparam int unsigned DH      = 4;
  localparam int unsigned LATENCY = 18 * DH;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] tx_byte_0 = 8'h00;
  logic [7:0] tx_byte_1 = 8'h00;
  logic       miso;
  logic [1:0] grant, done, cs_n;
  logic       busy, sclk, mosi;
  logic [7:0] rx_byte;

  logic       loop = 1'b1;
  logic       miso_val = 1'b0;
  bit         ptr = 1'b1;
  int         checks = 0;
  int         errors = 0;

  assign miso = loop ? mosi : miso_val;

  always #5 clk = ~clk;

  t05_spi_xfer_scheduler #(.DIV_HALF(DH)) dut (
    .current_clock_signal (clk),
    .reset                (reset),
    .req                  (req),
    .tx_byte_0            (tx_byte_0),
    .tx_byte_1            (tx_byte_1),
    .miso                 (miso),
    .grant                (grant),
    .busy                 (busy),
    .done                 (done),
    .rx_byte              (rx_byte),
    .sclk                 (sclk),
    .mosi                 (mosi),
    .cs_n                 (cs_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: the model predicts the winner, latency, and received byte.
  task automatic xfer(input string tag, input logic loop_en, input logic miso_c, input bit mutate);
    int         win;
    logic [1:0] exp_cs;
    logic [7:0] exp_rx;
    int         el, rises;
    logic       prev_sclk;
    bit         got, cs_ok, sclk_ok;
    loop     = loop_en;
    miso_val = miso_c;
    win      = (req == 2'b11) ? (ptr ? 0 : 1) : (req[1] ? 1 : 0);
    exp_cs   = (win == 1) ? 2'b01 : 2'b10;
    exp_rx   = loop_en ? ((win == 1) ? tx_byte_1 : tx_byte_0) : {8{miso_c}};
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (grant != 2'b00) got = 1'b1;
    end
    chk({tag, "_grant_seen"}, 32'(got), 32'd1);
    if (!got) return;
    chk({tag, "_grant"}, 32'(grant), (win == 1) ? 32'h2 : 32'h1);
    chk({tag, "_cs_start"}, 32'(cs_n), 32'(exp_cs));
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_sclk_start"}, 32'(sclk), 32'd0);
    el = 0; rises = 0; prev_sclk = sclk; cs_ok = 1'b1; sclk_ok = 1'b1; got = 1'b0;
    while (el < 100 && !got) begin
      step();
      el++;
      if (mutate && el == 10) begin
        tx_byte_0 = 8'h00;
        req       = 2'b00;
      end
      if (done != 2'b00) begin
        got = 1'b1;
      end else begin
        if (cs_n !== exp_cs) cs_ok = 1'b0;
        if (sclk && !prev_sclk) rises++;
        if ((el < int'(DH) || el >= int'(LATENCY - DH)) && sclk !== 1'b0) sclk_ok = 1'b0;
        prev_sclk = sclk;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (!got) return;
    chk({tag, "_latency"}, 32'(el), 32'(LATENCY));
    chk({tag, "_done"}, 32'(done), (win == 1) ? 32'h2 : 32'h1);
    chk({tag, "_rx"}, 32'(rx_byte), 32'(exp_rx));
    chk({tag, "_grant_end"}, 32'(grant), 32'd0);
    chk({tag, "_cs_end"}, 32'(cs_n), 32'h3);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    chk({tag, "_rises"}, 32'(rises), 32'd8);
    chk({tag, "_cs_stable"}, 32'(cs_ok), 32'd1);
    chk({tag, "_sclk_idle"}, 32'(sclk_ok), 32'd1);
    ptr = (win == 1);
    step();
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
  endtask

  initial begin
    int  mode;
    bit  got;
    // Reset state, with both requests already pending.
    req       = 2'b11;
    tx_byte_0 = 8'h3C;
    tx_byte_1 = 8'hC3;
    #2 reset = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_byte), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs", 32'(cs_n), 32'h3);
    step();
    step();
    reset = 1'b0;
    ptr   = 1'b1;

    // Round-robin with both requests held: 01,10,01,10.
    xfer("rr0", 1'b1, 1'b0, 1'b0);
    xfer("rr1", 1'b1, 1'b0, 1'b0);
    xfer("rr2", 1'b1, 1'b0, 1'b0);
    xfer("rr3", 1'b1, 1'b0, 1'b0);

    req = 2'b01; tx_byte_0 = 8'hA5;
    xfer("single_a5", 1'b1, 1'b0, 1'b0);
    xfer("miso_one", 1'b0, 1'b1, 1'b0);
    xfer("miso_zero", 1'b0, 1'b0, 1'b0);

    req = 2'b01; tx_byte_0 = 8'hA5;
    xfer("mutate", 1'b1, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      req       = 2'($urandom_range(1, 3));
      tx_byte_0 = 8'($urandom);
      tx_byte_1 = 8'($urandom);
      mode      = int'($urandom_range(0, 2));
      xfer($sformatf("rand%0d", k), (mode == 0), (mode == 2), 1'b0);
    end

    // Reset in the middle of the shift phase.
    req = 2'b01; tx_byte_0 = 8'($urandom); loop = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (grant != 2'b00) got = 1'b1;
    end
    chk("midrst_grant_seen", 32'(got), 32'd1);
    for (int i = 0; i < int'(DH + 6 * DH + 2); i++) step();
    reset = 1'b1;
    #1;
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_cs", 32'(cs_n), 32'h3);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx", 32'(rx_byte), 32'd0);
    step();
    step();
    req = 2'b10; tx_byte_1 = 8'h5A;
    reset = 1'b0;
    ptr   = 1'b1;
    xfer("post_rst", 1'b1, 1'b0, 1'b0);

    // No request: the block must stay idle.
    req = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant != 2'b00 || busy || cs_n != 2'b11 || sclk) got = 1'b1;
    end
    chk("quiet_idle", 32'(got), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
